sync_monitor: RTL and testbench
===============================

# sync_monitor

Lockstep synchronisation monitor for differential (variant) execution: two identical SoC harness instances, the reference DUT and the variant, run the same program. Each instance reports "sync events" carrying a tag. The monitor pairs each DUT event with the corresponding variant event. It measures the cycle skew between them, flags tag mismatches and ordering violations as divergence, and flags excessive skew as timeout. It sits in the top-level testbench beside the two harnesses and is the pass/fail oracle for divergence.

## Interface
- `DATA_W`, 64: tag width.
- `CNT_W`, 32: width of skew and sync counters.
- `MAX_SKEW`, 1024: maximum accepted skew in cycles, ≥1.

- `clock`  in  1  sampling clock shared with both harnesses.
- `reset`  in  1  reset, synchronous, active-low.
- `dut_valid`  in  1  DUT sync event this cycle.
- `dut_tag`  in  DATA_W  DUT event tag; valid when `dut_valid`.
- `vnt_valid`  in  1  variant sync event this cycle.
- `vnt_tag`  in  DATA_W  variant event tag; valid when `vnt_valid`.
- `sync_pulse`  out  1  one-cycle pulse: a pair matched.
- `diverge`  out  1  sticky: tag mismatch or order violation.
- `timeout`  out  1  sticky: partner missing after MAX_SKEW cycles.
- `skew_cycles`  out  CNT_W  skew of the last matched pair.
- `sync_count`  out  CNT_W  number of matched pairs, wraps.

## Operation
- FSM states:
  - IDLE: no pending event.
  - WAIT_VNT: DUT tag held, waiting for the variant.
  - WAIT_DUT: variant tag held, waiting for the DUT.
  - ERROR: terminal until reset.
- Transitions from IDLE:
  - Both valid: compare tags. If equal, it is a match with skew 0 and the FSM stays in IDLE. If unequal, go to ERROR and set `diverge`.
  - Only `dut_valid`: capture `dut_tag`, clear the skew counter, go to WAIT_VNT.
  - Only `vnt_valid`: symmetric, go to WAIT_DUT.
- In WAIT_VNT, the skew counter increments every cycle. Arrivals are handled as follows:
  - `vnt_valid` alone, tags equal: match with skew = counter+1, go to IDLE.
  - `vnt_valid` alone, tags unequal: go to ERROR with `diverge`.
  - `dut_valid` (second DUT event while one is pending), with or without `vnt_valid`: go to ERROR with `diverge`.
  - No partner by the time counter+1 reaches MAX_SKEW: go to ERROR with `timeout`.
  - A partner arriving in exactly that cycle is still matched; the match wins over the timeout.
- WAIT_DUT behaves symmetrically with the roles of DUT and variant swapped.
- On a match:
  - `sync_pulse` fires for one cycle.
  - `skew_cycles` is loaded with the measured skew.
  - `sync_count` increments, wrapping modulo 2^CNT_W.
- In ERROR, all inputs are ignored. `diverge` and `timeout` hold their value and the counters freeze. Only one of the two flags is ever set per error.
- Skew counter: CNT_W wide and saturating; MAX_SKEW must be less than 2^CNT_W.

## Timing
- All outputs are registered. The response appears in the cycle after the input cycle that caused it.
- While `reset`=0 at a rising edge:
  - FSM goes to IDLE.
  - `sync_pulse`, `diverge`, `timeout` = 0.
  - `skew_cycles`, `sync_count` = 0.
  - The captured tag is cleared.
- Reset overrides any pending wait or error.
- Inputs presented in the reset cycle are ignored.
- Skew definition: with the first event at cycle t0 and the partner at t1, skew = t1−t0.
- Timeout: if no partner arrives by t0+MAX_SKEW, `timeout` rises at t0+MAX_SKEW+1.
- Back-to-back matches in consecutive cycles are legal and produce consecutive `sync_pulse` cycles.

## Structure
- Package `sync_monitor_pkg` holds:
  - the state enum (IDLE, WAIT_VNT, WAIT_DUT, ERROR);
  - default values for DATA_W, CNT_W and MAX_SKEW.
- One sub-module, `sync_skew_counter`: clear/increment/saturate counter with a `reached` flag (counter+1 == MAX_SKEW).
- Tag capture and compare stay in `sync_monitor`.

## Test plan
- **Reset.** Hold reset=0 for 3 cycles, then release. Required: all outputs 0 and FSM in IDLE.
- **Simultaneous match.** dut/vnt valid in the same cycle, both tags 0x1234. Required: next cycle `sync_pulse`=1, `skew_cycles`=0, `sync_count`=1. Then 4 back-to-back equal pairs → `sync_count`=5.
- **Skewed match.** DUT tag 0xAA at t0, variant tag 0xAA at t0+7. Required: `sync_pulse` at t0+8 and `skew_cycles`=7. Repeat with variant first → same result.
- **Mismatch.** DUT tag 0x1, variant tag 0x2 at t0+3. Required: `diverge`=1 at t0+4 and held. Further matching pairs give no `sync_pulse`; `sync_count` unchanged.
- **Timeout boundary** (MAX_SKEW=16):
  - Partner at t0+16 → match with `skew_cycles`=16.
  - No partner → `timeout`=1 at t0+17, `diverge`=0.
- **Order violation and reset mid-error.** Two DUT events with no variant event in between. Required: `diverge`=1. Then reset=0 for 1 cycle → all outputs 0, and a fresh simultaneous pair matches.

Source files
------------

// File: rtl/sync_monitor_pkg.sv
// ============================================================================
// sync_monitor_pkg
//   Shared defaults and FSM state encoding for the lockstep sync monitor.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package sync_monitor_pkg;

  localparam int DEF_DATA_W   = 64;
  localparam int DEF_CNT_W    = 32;
  localparam int DEF_MAX_SKEW = 1024;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_WAIT_VNT = 2'd1;
  localparam state_t ST_WAIT_DUT = 2'd2;
  localparam state_t ST_ERROR    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/sync_monitor_if.sv
// ============================================================================
// sync_monitor_if
//   Event inputs from both harnesses plus the monitor verdict outputs.
//   Revision: 1.0
// ============================================================================
`default_nettype none

interface sync_monitor_if
  import sync_monitor_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
);

  logic              dut_valid;
  logic [DATA_W-1:0] dut_tag;
  logic              vnt_valid;
  logic [DATA_W-1:0] vnt_tag;
  logic              sync_pulse;
  logic              diverge;
  logic              timeout;
  logic [CNT_W-1:0]  skew_cycles;
  logic [CNT_W-1:0]  sync_count;

  modport master (
    output dut_valid, dut_tag, vnt_valid, vnt_tag,
    input  sync_pulse, diverge, timeout, skew_cycles, sync_count
  );

  modport slave (
    input  dut_valid, dut_tag, vnt_valid, vnt_tag,
    output sync_pulse, diverge, timeout, skew_cycles, sync_count
  );

endinterface

`default_nettype wire

// File: rtl/sync_skew_counter.sv
// ============================================================================
// sync_skew_counter
//   Clear/increment saturating counter; reached_o flags counter+1 == MAX_SKEW.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module sync_skew_counter
  import sync_monitor_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int MAX_SKEW = DEF_MAX_SKEW
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             clr_i,
  input  wire logic             inc_i,
  output logic [CNT_W-1:0]      cnt_o,
  output logic                  reached_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign reached_o = ((cnt_q + CNT_W'(1)) == CNT_W'(MAX_SKEW));

endmodule

`default_nettype wire

// File: rtl/sync_monitor.sv
// ============================================================================
// sync_monitor
//   Pairs DUT and variant sync events, measures skew, flags divergence/timeout.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module sync_monitor
  import sync_monitor_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int MAX_SKEW = DEF_MAX_SKEW
) (
  input  wire logic      clock,
  input  wire logic      reset,
  sync_monitor_if.slave  bus
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tag_q, tag_d;
  logic              pulse_q, pulse_d;
  logic              diverge_q, diverge_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  skew_q, skew_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              cnt_clr;
  logic              cnt_inc;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_reached;

  // Partner view of the pending wait: which side is held and which side completes it.
  logic              same_valid;
  logic              other_valid;
  logic [DATA_W-1:0] other_tag;

  sync_skew_counter #(
    .CNT_W    (CNT_W),
    .MAX_SKEW (MAX_SKEW)
  ) u_skew_counter (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (cnt_clr),
    .inc_i     (cnt_inc),
    .cnt_o     (cnt_val),
    .reached_o (cnt_reached)
  );

  always_comb begin
    same_valid  = (state_q == ST_WAIT_VNT) ? bus.dut_valid : bus.vnt_valid;
    other_valid = (state_q == ST_WAIT_VNT) ? bus.vnt_valid : bus.dut_valid;
    other_tag   = (state_q == ST_WAIT_VNT) ? bus.vnt_tag   : bus.dut_tag;
  end

  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    pulse_d   = 1'b0;
    diverge_d = diverge_q;
    timeout_d = timeout_q;
    skew_d    = skew_q;
    count_d   = count_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.dut_valid && bus.vnt_valid) begin
          if (bus.dut_tag == bus.vnt_tag) begin
            pulse_d = 1'b1;
            skew_d  = '0;
            count_d = count_q + CNT_W'(1);
          end else begin
            diverge_d = 1'b1;
            state_d   = ST_ERROR;
          end
        end else if (bus.dut_valid) begin
          tag_d   = bus.dut_tag;
          cnt_clr = 1'b1;
          state_d = ST_WAIT_VNT;
        end else if (bus.vnt_valid) begin
          tag_d   = bus.vnt_tag;
          cnt_clr = 1'b1;
          state_d = ST_WAIT_DUT;
        end
      end

      ST_WAIT_VNT, ST_WAIT_DUT: begin
        cnt_inc = 1'b1;
        if (same_valid) begin
          diverge_d = 1'b1;
          state_d   = ST_ERROR;
        end else if (other_valid) begin
          if (other_tag == tag_q) begin
            pulse_d = 1'b1;
            skew_d  = cnt_val + CNT_W'(1);
            count_d = count_q + CNT_W'(1);
            state_d = ST_IDLE;
          end else begin
            diverge_d = 1'b1;
            state_d   = ST_ERROR;
          end
        end else if (cnt_reached) begin
          timeout_d = 1'b1;
          state_d   = ST_ERROR;
        end
      end

      default: begin
        state_d = ST_ERROR;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      tag_q     <= '0;
      pulse_q   <= 1'b0;
      diverge_q <= 1'b0;
      timeout_q <= 1'b0;
      skew_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      pulse_q   <= pulse_d;
      diverge_q <= diverge_d;
      timeout_q <= timeout_d;
      skew_q    <= skew_d;
      count_q   <= count_d;
    end
  end

  assign bus.sync_pulse  = pulse_q;
  assign bus.diverge     = diverge_q;
  assign bus.timeout     = timeout_q;
  assign bus.skew_cycles = skew_q;
  assign bus.sync_count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_monitor.sv
// ============================================================================
// tb_sync_monitor
//   Directed and randomized checks of sync_monitor against a timestamp model.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sync_monitor;

  localparam int DATA_W   = 64;
  localparam int CNT_W    = 32;
  localparam int MAX_SKEW = 16;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  sync_monitor_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  sync_monitor #(
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W),
    .MAX_SKEW (MAX_SKEW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: events carry timestamps; skew is a timestamp difference.
  int                m_now;
  bit                m_err;
  bit                m_pend;
  bit                m_pend_dut;
  logic [DATA_W-1:0] m_pend_tag;
  int                m_pend_t0;
  logic              e_pulse;
  logic              e_div;
  logic              e_to;
  logic [CNT_W-1:0]  e_skew;
  logic [CNT_W-1:0]  e_cnt;

  task automatic model_reset();
    m_now = 0; m_err = 0; m_pend = 0; m_pend_dut = 0; m_pend_tag = '0; m_pend_t0 = 0;
    e_pulse = 0; e_div = 0; e_to = 0; e_skew = '0; e_cnt = '0;
  endtask

  task automatic model_match(input int skew);
    e_pulse = 1'b1;
    e_skew  = CNT_W'(skew);
    e_cnt   = e_cnt + 1;
    m_pend  = 0;
  endtask

  task automatic model_step(input logic dv, input logic [DATA_W-1:0] dt,
                            input logic vv, input logic [DATA_W-1:0] vt);
    logic              same_side;
    logic              other_side;
    logic [DATA_W-1:0] other_tag;
    e_pulse = 1'b0;
    if (!m_err) begin
      if (!m_pend) begin
        if (dv && vv) begin
          if (dt == vt) model_match(0);
          else begin e_div = 1'b1; m_err = 1; end
        end else if (dv || vv) begin
          m_pend = 1; m_pend_dut = dv; m_pend_tag = dv ? dt : vt; m_pend_t0 = m_now;
        end
      end else begin
        same_side  = m_pend_dut ? dv : vv;
        other_side = m_pend_dut ? vv : dv;
        other_tag  = m_pend_dut ? vt : dt;
        if (same_side) begin
          e_div = 1'b1; m_err = 1;
        end else if (other_side) begin
          if (other_tag == m_pend_tag) model_match(m_now - m_pend_t0);
          else begin e_div = 1'b1; m_err = 1; end
        end else if (m_now - m_pend_t0 >= MAX_SKEW) begin
          e_to = 1'b1; m_err = 1;
        end
      end
    end
    m_now++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("sync_pulse",  64'(bus.sync_pulse),  64'(e_pulse));
    chk("diverge",     64'(bus.diverge),     64'(e_div));
    chk("timeout",     64'(bus.timeout),     64'(e_to));
    chk("skew_cycles", 64'(bus.skew_cycles), 64'(e_skew));
    chk("sync_count",  64'(bus.sync_count),  64'(e_cnt));
  endtask

  function automatic logic [DATA_W-1:0] rnd_tag();
    return {$urandom, $urandom};
  endfunction

  // One input cycle: drive, advance the model, sample #1 after the edge.
  task automatic cyc(input logic dv, input logic [DATA_W-1:0] dt,
                     input logic vv, input logic [DATA_W-1:0] vt);
    bus.dut_valid = dv; bus.dut_tag = dt;
    bus.vnt_valid = vv; bus.vnt_tag = vt;
    model_step(dv, dt, vv, vt);
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, rnd_tag(), 1'b0, rnd_tag());
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) begin
      bus.dut_valid = 1'($urandom); bus.dut_tag = rnd_tag();
      bus.vnt_valid = 1'($urandom); bus.vnt_tag = rnd_tag();
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    model_reset();
    check_all();
  endtask

  task automatic skewed_pair(input bit dut_first, input logic [DATA_W-1:0] t1,
                             input logic [DATA_W-1:0] t2, input int skew, input bit noisy);
    if (skew == 0) begin
      cyc(1'b1, t1, 1'b1, t2);
    end else begin
      if (dut_first) cyc(1'b1, t1, 1'b0, rnd_tag());
      else           cyc(1'b0, rnd_tag(), 1'b1, t1);
      for (int i = 1; i < skew; i++) begin
        if (noisy && ($urandom_range(0, 39) == 0)) cyc(1'b1, t1, 1'b1, t1);
        else idle();
      end
      if (dut_first) cyc(1'b0, rnd_tag(), 1'b1, t2);
      else           cyc(1'b1, t2, 1'b0, rnd_tag());
    end
  endtask

  initial begin
    logic [DATA_W-1:0] t;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.dut_valid = 1'b0; bus.dut_tag = '0;
    bus.vnt_valid = 1'b0; bus.vnt_tag = '0;
    model_reset();
    #1;

    // Reset
    do_reset(3);
    chk("reset_count", 64'(bus.sync_count), 64'd0);

    // Simultaneous match and back-to-back pairs
    cyc(1'b1, 64'h1234, 1'b1, 64'h1234);
    chk("simul_pulse", 64'(bus.sync_pulse), 64'd1);
    chk("simul_skew",  64'(bus.skew_cycles), 64'd0);
    chk("simul_count", 64'(bus.sync_count), 64'd1);
    for (int i = 0; i < 4; i++) begin
      t = rnd_tag();
      cyc(1'b1, t, 1'b1, t);
    end
    chk("b2b_count", 64'(bus.sync_count), 64'd5);
    idle();
    chk("b2b_pulse_drop", 64'(bus.sync_pulse), 64'd0);

    // Skewed match, both orders
    skewed_pair(1'b1, 64'hAA, 64'hAA, 7, 1'b0);
    chk("skew_dut_first", 64'(bus.skew_cycles), 64'd7);
    chk("skew_dut_pulse", 64'(bus.sync_pulse), 64'd1);
    idle();
    skewed_pair(1'b0, 64'hAA, 64'hAA, 7, 1'b0);
    chk("skew_vnt_first", 64'(bus.skew_cycles), 64'd7);
    chk("skew_count", 64'(bus.sync_count), 64'd7);

    // Mismatch: diverge held, later pairs ignored
    skewed_pair(1'b1, 64'h1, 64'h2, 3, 1'b0);
    chk("mismatch_div", 64'(bus.diverge), 64'd1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 64'h55, 1'b1, 64'h55);
    chk("err_no_pulse", 64'(bus.sync_pulse), 64'd0);
    chk("err_count",    64'(bus.sync_count), 64'd7);
    chk("err_div_held", 64'(bus.diverge), 64'd1);

    // Timeout boundary
    do_reset(1);
    skewed_pair(1'b1, 64'h77, 64'h77, MAX_SKEW, 1'b0);
    chk("edge_match_skew", 64'(bus.skew_cycles), 64'(MAX_SKEW));
    chk("edge_no_timeout", 64'(bus.timeout), 64'd0);
    cyc(1'b1, 64'h99, 1'b0, '0);
    for (int i = 0; i < MAX_SKEW; i++) idle();
    chk("timeout_set",  64'(bus.timeout), 64'd1);
    chk("timeout_nodiv", 64'(bus.diverge), 64'd0);

    // Order violation then reset mid-error
    do_reset(1);
    cyc(1'b1, 64'h3, 1'b0, '0);
    idle();
    cyc(1'b1, 64'h4, 1'b0, '0);
    chk("order_div", 64'(bus.diverge), 64'd1);
    do_reset(1);
    chk("rst_div", 64'(bus.diverge), 64'd0);
    cyc(1'b1, 64'hBEEF, 1'b1, 64'hBEEF);
    chk("post_rst_count", 64'(bus.sync_count), 64'd1);

    // Randomized traffic against the model
    for (int r = 0; r < 20; r++) begin
      do_reset($urandom_range(1, 2));
      for (int k = 0; k < 10; k++) begin
        t = rnd_tag();
        skewed_pair(1'($urandom), t,
                    ($urandom_range(0, 7) == 0) ? (t ^ 64'h1) : t,
                    $urandom_range(0, MAX_SKEW + 2), 1'b1);
        repeat ($urandom_range(0, 2)) idle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
